pwm_config_sequencer: RTL
=========================

# pwm_config_sequencer

Sequencer between the gated front-panel commands and the PWM generator datapath. It converts level commands (frequency up/down, duty up/down, mode, master reset) into single update events with hold-to-repeat, applies saturating arithmetic to the frequency index and duty registers, and hands each new configuration to the datapath over a valid/ready handshake. It sits directly downstream of the main control gating stage.

## Interface
- FREQ_W, 4, frequency index width
- FREQ_MAX, 9, highest frequency index
- FREQ_RST, 0, frequency index after reset
- DUTY_W, 7, duty width in percent
- DUTY_STEP, 10, duty increment and minimum duty
- DUTY_MAX, 100, maximum duty
- DUTY_RST, 50, duty after reset
- HOLD_CYC, 16, cycles held before auto-repeat starts
- REP_CYC, 4, cycles between repeats
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset; synchronous, active-high
- en_i  in  1  command enable; events are generated only while high
- aumf_i, bajaf_i  in  1  frequency up/down level
- aumC_i, bajaC_i  in  1  duty up/down level
- modo_i  in  1  mode toggle level
- mrst_i  in  1  master (configuration) reset level
- cfg_ready_i  in  1  datapath accepts the configuration
- freq_o  out  FREQ_W  frequency index
- duty_o  out  DUTY_W  duty percent
- modo_o  out  1  current mode
- cfg_valid_o  out  1  new configuration offered
- busy_o  out  1  high while in the OFFER state

## Operation
- Edge detect: all six inputs are registered every cycle. An event fires when the input is 1, the previous sample was 0, and en_i=1.
- Auto-repeat applies to aum/baja only.
  - A shared hold counter restarts whenever the registered vector of the four level inputs changes.
  - After HOLD_CYC cycles with the vector unchanged and non-zero, a repeat event fires, then one every REP_CYC cycles.
  - Repeats require en_i=1.
- States:
  - IDLE: waits for events. It leaves IDLE only when an event changes a value or is mrst.
  - OFFER: cfg_valid_o=1 until cfg_ready_i=1, then returns to IDLE, or to OFFER_RST if mrst is pending.
  - OFFER_RST: loads the reset values and offers them, then behaves as OFFER.
- Event merging in IDLE:
  - mrst overrides everything else and loads FREQ_RST, DUTY_RST, modo=0. It is always offered, even when the values are unchanged.
  - Otherwise modo toggles, and frequency and duty updates are applied together in one update.
- Same-axis up+down in one cycle cancel each other, with no change on that axis.
- Arithmetic:
  - freq saturates to [0, FREQ_MAX].
  - duty is computed in DUTY_W+1 bits and clamped to [DUTY_STEP, DUTY_MAX].
  - An update whose result equals the current values produces no handshake.
- Events in OFFER and OFFER_RST:
  - aum/baja/modo events are dropped.
  - An mrst event sets a pending flag, which is cleared on entry to OFFER_RST.
- rst_i at any point forces IDLE, clears pending and loads the reset values.

## Timing
- Reset values: freq_o=FREQ_RST, duty_o=DUTY_RST, modo_o=0, cfg_valid_o=0, busy_o=0, counters=0.
- Latency: input rises at edge n (first sample = 1). Outputs and cfg_valid_o change at edge n+1.
- Outputs stay stable while cfg_valid_o=1.
- Transfer happens at the edge where cfg_valid_o and cfg_ready_i are both 1. cfg_valid_o is low the next cycle unless a pending mrst leads to OFFER_RST, which raises valid one cycle later.
- Minimum spacing between accepted updates is 2 cycles.
- Auto-repeat timing: the first repeat fires HOLD_CYC cycles after the press event, the next ones every REP_CYC cycles.

## Structure
- Package pwm_cfg_pkg contains:
  - the state enum (IDLE, OFFER, OFFER_RST);
  - the default values for FREQ_MAX, DUTY_STEP, DUTY_MAX, FREQ_RST, DUTY_RST;
  - a function that clamps duty.
- Sub-module button_event_gen handles edge detection and hold/repeat counting and outputs per-input event pulses. It is instantiated once.
- The top level contains the FSM, the merge logic and the output registers.

## Test plan
- Reset, then one aumf pulse with ready tied to 1 → freq_o goes 0→1 one edge after the rise; cfg_valid_o is high for 1 cycle.
- Set duty to 90, then press aumC twice → 100, after which there is no further handshake. Press bajaC ten times from 50 → duty stops at 10.
- Hold aumf for 40 cycles with HOLD_CYC=16, REP_CYC=4 → events at press, +16, +20, +24, … Then release and hold both aumf and bajaf → no change.
- Hold cfg_ready_i=0 and press aumC then mrst during OFFER → the aumC event is dropped. After ready, an OFFER_RST follows with freq=0, duty=50, modo=0.
- Press with en_i=0 → no event; the hold counter runs, but no repeats fire.
- Assert rst_i mid-OFFER → the next cycle shows cfg_valid_o=0 and all outputs at their reset values.

Source files
------------

// File: rtl/pwm_cfg_pkg.sv
// Shared types, default geometry and duty clamping for the PWM configuration sequencer.
package pwm_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOffer,
    StOfferRst
  } cfg_state_e;

  localparam int unsigned DefFreqW    = 4;
  localparam int unsigned DefFreqMax  = 9;
  localparam int unsigned DefFreqRst  = 0;
  localparam int unsigned DefDutyW    = 7;
  localparam int unsigned DefDutyStep = 10;
  localparam int unsigned DefDutyMax  = 100;
  localparam int unsigned DefDutyRst  = 50;
  localparam int unsigned DefHoldCyc  = 16;
  localparam int unsigned DefRepCyc   = 4;

  // Button vector layout; the repeatable level inputs occupy the low NumRep bits.
  localparam int unsigned NumBtn   = 6;
  localparam int unsigned NumRep   = 4;
  localparam int unsigned BtnAumf  = 0;
  localparam int unsigned BtnBajaf = 1;
  localparam int unsigned BtnAumC  = 2;
  localparam int unsigned BtnBajaC = 3;
  localparam int unsigned BtnModo  = 4;
  localparam int unsigned BtnMrst  = 5;

  function automatic int unsigned clamp_duty(int unsigned val, int unsigned lo, int unsigned hi);
    int unsigned res;
    res = val;
    if (val < lo) begin
      res = lo;
    end else if (val > hi) begin
      res = hi;
    end
    return res;
  endfunction

endpackage

// File: rtl/button_event_gen.sv
// Registers the six command levels, turns rising edges into event pulses and adds
// hold-to-repeat pulses for the four up/down levels.
module button_event_gen
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned HoldCyc = DefHoldCyc,
  parameter int unsigned RepCyc  = DefRepCyc
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [NumBtn-1:0] i_btn,
  output logic [NumBtn-1:0] o_ev
);

  localparam int unsigned MaxCyc = (HoldCyc > RepCyc) ? HoldCyc : RepCyc;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  logic [NumBtn-1:0] r_smp;
  logic [NumBtn-1:0] r_smp_d;
  logic [CntW-1:0]   r_cnt;
  logic              r_rep;

  logic [NumRep-1:0] w_lvl;
  logic [NumRep-1:0] w_lvl_d;
  logic              w_chg;
  logic              w_held;
  logic              w_fire;
  logic [NumBtn-1:0] w_rep_ev;

  assign w_lvl   = r_smp[NumRep-1:0];
  assign w_lvl_d = r_smp_d[NumRep-1:0];
  assign w_chg   = (w_lvl != w_lvl_d);
  assign w_held  = (w_lvl != '0) && !w_chg;
  // Counter reads j in the j-th cycle after a vector change, so the first repeat
  // lands exactly HoldCyc cycles after the press event.
  assign w_fire  = w_held && (r_rep ? (r_cnt == CntW'(RepCyc)) : (r_cnt == CntW'(HoldCyc)));

  assign w_rep_ev = {{(NumBtn - NumRep){1'b0}}, w_lvl & {NumRep{w_fire}}};
  assign o_ev     = {NumBtn{i_en}} & ((r_smp & ~r_smp_d) | w_rep_ev);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_smp   <= '0;
      r_smp_d <= '0;
      r_cnt   <= '0;
      r_rep   <= 1'b0;
    end else begin
      r_smp   <= i_btn;
      r_smp_d <= r_smp;
      if (w_chg) begin
        r_cnt <= CntW'(1);
        r_rep <= 1'b0;
      end else if (w_lvl == '0) begin
        r_cnt <= '0;
        r_rep <= 1'b0;
      end else if (w_fire) begin
        r_cnt <= CntW'(1);
        r_rep <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_config_sequencer.sv
// Merges front-panel command events into saturating frequency/duty/mode updates and
// offers each new configuration to the PWM datapath over a valid/ready handshake.
module pwm_config_sequencer
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned FREQ_W    = DefFreqW,
  parameter int unsigned FREQ_MAX  = DefFreqMax,
  parameter int unsigned FREQ_RST  = DefFreqRst,
  parameter int unsigned DUTY_W    = DefDutyW,
  parameter int unsigned DUTY_STEP = DefDutyStep,
  parameter int unsigned DUTY_MAX  = DefDutyMax,
  parameter int unsigned DUTY_RST  = DefDutyRst,
  parameter int unsigned HOLD_CYC  = DefHoldCyc,
  parameter int unsigned REP_CYC   = DefRepCyc
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              aumf_i,
  input  logic              bajaf_i,
  input  logic              aumC_i,
  input  logic              bajaC_i,
  input  logic              modo_i,
  input  logic              mrst_i,
  input  logic              cfg_ready_i,
  output logic [FREQ_W-1:0] freq_o,
  output logic [DUTY_W-1:0] duty_o,
  output logic              modo_o,
  output logic              cfg_valid_o,
  output logic              busy_o
);

  localparam int unsigned DutyExtW = DUTY_W + 1;

  cfg_state_e        r_state;
  logic [FREQ_W-1:0] r_freq;
  logic [DUTY_W-1:0] r_duty;
  logic              r_modo;
  logic              r_valid;
  logic              r_busy;
  logic              r_pend;

  logic [NumBtn-1:0]   w_btn;
  logic [NumBtn-1:0]   w_ev;
  logic                w_f_up;
  logic                w_f_dn;
  logic                w_d_up;
  logic                w_d_dn;
  logic [FREQ_W-1:0]   w_freq_nxt;
  logic [DutyExtW-1:0] w_duty_ext;
  logic [DutyExtW-1:0] w_duty_sum;
  logic [DUTY_W-1:0]   w_duty_nxt;
  logic                w_modo_nxt;
  logic                w_upd;

  assign w_btn = {mrst_i, modo_i, bajaC_i, aumC_i, bajaf_i, aumf_i};

  button_event_gen #(
    .HoldCyc (HOLD_CYC),
    .RepCyc  (REP_CYC)
  ) u_btn_ev (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (en_i),
    .i_btn (w_btn),
    .o_ev  (w_ev)
  );

  // Opposite commands on one axis in the same cycle cancel.
  assign w_f_up = w_ev[BtnAumf] & ~w_ev[BtnBajaf];
  assign w_f_dn = w_ev[BtnBajaf] & ~w_ev[BtnAumf];
  assign w_d_up = w_ev[BtnAumC] & ~w_ev[BtnBajaC];
  assign w_d_dn = w_ev[BtnBajaC] & ~w_ev[BtnAumC];

  assign w_duty_ext = {1'b0, r_duty};

  always_comb begin
    w_freq_nxt = r_freq;
    if (w_f_up && (r_freq < FREQ_W'(FREQ_MAX))) begin
      w_freq_nxt = r_freq + FREQ_W'(1);
    end else if (w_f_dn && (r_freq != '0)) begin
      w_freq_nxt = r_freq - FREQ_W'(1);
    end

    w_duty_sum = w_duty_ext;
    if (w_d_up) begin
      w_duty_sum = w_duty_ext + DutyExtW'(DUTY_STEP);
    end else if (w_d_dn) begin
      w_duty_sum = (w_duty_ext >= DutyExtW'(DUTY_STEP)) ? w_duty_ext - DutyExtW'(DUTY_STEP) : '0;
    end
    w_duty_nxt = DUTY_W'(clamp_duty(32'(w_duty_sum), DUTY_STEP, DUTY_MAX));

    w_modo_nxt = r_modo ^ w_ev[BtnModo];
    w_upd      = (w_freq_nxt != r_freq) || (w_duty_nxt != r_duty) || w_ev[BtnModo];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_freq  <= FREQ_W'(FREQ_RST);
      r_duty  <= DUTY_W'(DUTY_RST);
      r_modo  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_ev[BtnMrst]) begin
            r_freq  <= FREQ_W'(FREQ_RST);
            r_duty  <= DUTY_W'(DUTY_RST);
            r_modo  <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= StOffer;
          end else if (w_upd) begin
            r_freq  <= w_freq_nxt;
            r_duty  <= w_duty_nxt;
            r_modo  <= w_modo_nxt;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= StOffer;
          end
        end
        StOffer: begin
          if (cfg_ready_i) begin
            r_valid <= 1'b0;
            if (r_pend || w_ev[BtnMrst]) begin
              r_pend  <= 1'b0;
              r_state <= StOfferRst;
            end else begin
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end
          end else begin
            r_pend <= r_pend | w_ev[BtnMrst];
          end
        end
        StOfferRst: begin
          r_freq  <= FREQ_W'(FREQ_RST);
          r_duty  <= DUTY_W'(DUTY_RST);
          r_modo  <= 1'b0;
          r_valid <= 1'b1;
          r_pend  <= r_pend | w_ev[BtnMrst];
          r_state <= StOffer;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign freq_o      = r_freq;
  assign duty_o      = r_duty;
  assign modo_o      = r_modo;
  assign cfg_valid_o = r_valid;
  assign busy_o      = r_busy;

endmodule
